// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with RAW/WAW scoreboard stall; DECODE_WB_BYPASS_EN lets same-cycle writeback clear a hazard
module decode_stage #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int STALL_CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:ADDRESS_SIZE-1]       instruction,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          register_write,
    output logic [0:REG_ADDRESS_SIZE-1]   addr_rd,
    output logic [0:REG_ADDRESS_SIZE-1]   addr_r1,
    output logic [0:REG_ADDRESS_SIZE-1]   addr_r2,
    output logic [0:ADDRESS_SIZE-1]       immediate,
    output logic                          illegal,
    input  logic                          wb_valid,
    input  logic [0:REG_ADDRESS_SIZE-1]   wb_addr,
    output logic [0:STALL_CNT_W-1]        stall_count
);
    localparam int R  = REG_ADDRESS_SIZE;
    localparam int A  = ADDRESS_SIZE;
    localparam int IW = A - 7 - 3 * R;
    localparam int N  = 2 ** R;

    logic [6:0]   op;
    logic [0:R-1] rd, r1, r2;
    logic [0:A-1] imm;
    logic         wr, rs1, rs2, ill, rw, hazard, accept;
    logic [N-1:0] pending, busy, clr, set;

    always_comb begin
        op     = instruction[0:6];
        rd     = instruction[7:7+R-1];
        r1     = instruction[7+R:7+2*R-1];
        r2     = instruction[7+2*R:7+3*R-1];
        imm    = {{(A-IW){instruction[7+3*R]}}, instruction[7+3*R:A-1]};
        wr     = op == 7'd1 || op == 7'd2 || op == 7'd3;
        rs1    = op >= 7'd1 && op <= 7'd5;
        rs2    = op == 7'd1 || op == 7'd4 || op == 7'd5;
        ill    = op > 7'd5;
        rw     = wr && rd != '0;
        clr    = wb_valid ? N'(1) << wb_addr : '0;
`ifdef DECODE_WB_BYPASS_EN
        busy   = pending & ~clr;
`else
        busy   = pending;
`endif
        hazard = in_valid && ((rs1 && r1 != '0 && busy[r1]) ||
                              (rs2 && r2 != '0 && busy[r2]) ||
                              (rw && busy[rd]));
        in_ready = (!out_valid || out_ready) && !hazard;
        accept   = in_valid && in_ready;
        set      = (accept && rw) ? N'(1) << rd : '0;
    end

    // set is OR-ed after the clear so a same-cycle issue to the retiring register keeps it pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            register_write <= 1'b0;
            addr_rd        <= '0;
            addr_r1        <= '0;
            addr_r2        <= '0;
            immediate      <= '0;
            illegal        <= 1'b0;
            stall_count    <= '0;
            pending        <= '0;
        end else begin
            if (accept) begin
                out_valid      <= 1'b1;
                register_write <= rw;
                addr_rd        <= rd;
                addr_r1        <= r1;
                addr_r2        <= r2;
                immediate      <= imm;
                illegal        <= ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            pending <= (pending & ~clr) | set;
            if (hazard && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage; honours DECODE_WB_BYPASS_EN
module tb_decode_stage;
`ifdef DECODE_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:31] instruction = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        register_write;
    logic [0:4]  addr_rd, addr_r1, addr_r2;
    logic [0:31] immediate;
    logic        illegal;
    logic        wb_valid = 1'b0;
    logic [0:4]  wb_addr = '0;
    logic [0:15] stall_count;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd, r1, r2;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_sc = 0;
    int   st;

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .register_write(register_write), .addr_rd(addr_rd), .addr_r1(addr_r1),
        .addr_r2(addr_r2), .immediate(immediate), .illegal(illegal),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd, r1, r2, input logic [9:0] im);
        exp_t e;
        e.rw  = (op == 7'd1 || op == 7'd2 || op == 7'd3) && rd != 5'd0;
        e.rd  = rd;
        e.r1  = r1;
        e.r2  = r2;
        e.imm = {{22{im[9]}}, im};
        e.ill = op > 7'd5;
        return e;
    endfunction

    task automatic present(input logic [6:0] op, input logic [4:0] rd, r1, r2, input logic [9:0] im);
        in_valid    = 1'b1;
        instruction = {op, rd, r1, r2, im};
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, r1, r2, input logic [9:0] im, output int stalls);
        stalls = 0;
        present(op, rd, r1, r2, im);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            @(posedge clk);
        end
        if (!in_ready) begin
            check("accept timeout", 0, 1);
            @(posedge clk);
        end else begin
            @(posedge clk);
            q.push_back(model(op, rd, r1, r2, im));
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a);
        wb_valid = 1'b1;
        wb_addr  = a;
        @(posedge clk);
        #1 wb_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid) begin
            if (q.size() == 0) begin
                check("spurious out_valid", 1, 0);
            end else begin
                check("register_write", register_write, q[0].rw);
                check("addr_rd", addr_rd, q[0].rd);
                check("addr_r1", addr_r1, q[0].r1);
                check("addr_r2", addr_r2, q[0].r2);
                check("immediate", immediate, q[0].imm);
                check("illegal", illegal, q[0].ill);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst register_write", register_write, 0);
        check("rst addr", {addr_rd, addr_r1, addr_r2}, 0);
        check("rst immediate", immediate, 0);
        check("rst illegal", illegal, 0);
        check("rst stall_count", stall_count, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("idle in_ready", in_ready, 1);
        check("idle out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        send(7'd2, 5'd3, 5'd1, 5'd0, 10'h3FF, st);
        check("alu_ri stalls", st, 0);
        @(negedge clk);
        check("latency out_valid", out_valid, 1);
        @(posedge clk);
        #1 wb(5'd3);

        send(7'd1, 5'd3, 5'd1, 5'd2, 10'h000, st);
        check("alu_rr stalls", st, 0);
        fork
            send(7'd1, 5'd4, 5'd3, 5'd0, 10'h000, st);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("raw in_ready", in_ready, 0);
                    check("stall_count step", stall_count, exp_sc + i);
                    @(posedge clk);
                end
                #1 wb_valid = 1'b1;
                wb_addr = 5'd3;
                @(posedge clk);
                #1 wb_valid = 1'b0;
            end
        join
        check("raw stall cycles", st, BYP ? 4 : 5);
        exp_sc += BYP ? 4 : 5;
        check("raw stall_count", stall_count, exp_sc);

        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        send(7'd2, 5'd5, 5'd1, 5'd0, 10'h003, st);
        wb_valid = 1'b0;
        check("set-wins issue stalls", st, 0);
        present(7'd3, 5'd8, 5'd5, 5'd0, 10'h000);
        @(negedge clk);
        check("set-wins in_ready", in_ready, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_sc++;
        wb(5'd5);
        send(7'd3, 5'd8, 5'd5, 5'd0, 10'h000, st);
        check("after wb stalls", st, 0);
        check("set-wins stall_count", stall_count, exp_sc);

        send(7'h7F, 5'd6, 5'd6, 5'd6, 10'h155, st);
        check("illegal stalls", st, 0);
        send(7'd1, 5'd6, 5'd6, 5'd6, 10'h200, st);
        check("after illegal stalls", st, 0);

        out_ready = 1'b0;
        fork
            send(7'd4, 5'd0, 5'd10, 5'd11, 10'h07F, st);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("hold in_ready", in_ready, 0);
                    check("hold out_valid", out_valid, 1);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        check("hold stalls", st, 3);
        check("hold stall_count", stall_count, exp_sc);

        send(7'd2, 5'd0, 5'd0, 5'd0, 10'h005, st);
        check("rd0 stalls", st, 0);
        send(7'd1, 5'd7, 5'd0, 5'd0, 10'h000, st);
        check("read r0 stalls", st, 0);

        send(7'd2, 5'd12, 5'd0, 5'd0, 10'h001, st);
        present(7'd3, 5'd13, 5'd12, 5'd0, 10'h000);
        @(negedge clk);
        check("pre-reset in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check("midrst out_valid", out_valid, 0);
        check("midrst stall_count", stall_count, 0);
        check("midrst register_write", register_write, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        send(7'd3, 5'd13, 5'd12, 5'd0, 10'h000, st);
        check("post-reset stalls", st, 0);

        repeat (3) @(negedge clk);
        check("queue drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined successor to the combinational-field Decoder.
- Accepts one instruction per cycle over a valid/ready handshake and decodes it into register addresses, write enable, sign-extended immediate and an illegal flag.
- Presents the result from a single output register to the issue stage.
- A per-register scoreboard, cleared by writeback, stalls RAW/WAW hazards; a saturating counter records stall cycles.

Parameters:
- ADDRESS_SIZE, 32: instruction and immediate width. Must be >= 7+3*REG_ADDRESS_SIZE+1.
- REG_ADDRESS_SIZE, 5: register-address field width; the scoreboard has 2**REG_ADDRESS_SIZE entries.
- STALL_CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept (combinational).
- instruction  in  [0:ADDRESS_SIZE-1]  bit 0 is MSB.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts.
- register_write  out  1  instruction writes rd.
- addr_rd  out  [0:REG_ADDRESS_SIZE-1]  destination register.
- addr_r1  out  [0:REG_ADDRESS_SIZE-1]  source 1.
- addr_r2  out  [0:REG_ADDRESS_SIZE-1]  source 2.
- immediate  out  [0:ADDRESS_SIZE-1]  sign-extended immediate.
- illegal  out  1  unknown opcode.
- wb_valid  in  1  writeback retiring a register.
- wb_addr  in  [0:REG_ADDRESS_SIZE-1]  register being retired.
- stall_count  out  [0:STALL_CNT_W-1]  saturating hazard-stall cycle count.

Behaviour:
- Instruction fields, with R = REG_ADDRESS_SIZE:
  - opcode = bits [0:6]
  - rd = [7:7+R-1]
  - r1 = next R bits
  - r2 = next R bits
  - imm = remaining bits, sign-extended from its bit 0 to ADDRESS_SIZE.
- Opcodes (writes rd / reads):
  - 0 NOP: no write, reads none.
  - 1 ALU_RR: write, reads r1, r2.
  - 2 ALU_RI: write, reads r1.
  - 3 LOAD: write, reads r1.
  - 4 STORE: no write, reads r1, r2.
  - 5 BRANCH: no write, reads r1, r2.
  - Any other opcode: illegal=1, register_write=0, no scoreboard access, still passed downstream.
- A write to register 0 is forced to register_write=0. Register 0 is never pending.
- Hazard (combinational) when in_valid is high and any of the following holds:
  - a read source that is non-zero is pending in the scoreboard;
  - the instruction writes rd, rd is non-zero and rd is pending (WAW).
- in_ready = (!out_valid | out_ready) & !hazard.
- Accept = in_valid & in_ready.
  - On accept: the output register loads the decoded fields and out_valid=1.
  - If register_write is set: pending[rd] is set.
- If out_valid & out_ready and no accept: out_valid=0.
- Latency: accept in cycle N gives out_valid in cycle N+1.
- While out_valid & !out_ready, the outputs hold stable.
- Scoreboard:
  - wb_valid clears pending[wb_addr] at the clock edge.
  - If an accept sets the same register in the same cycle, the set wins (pending stays 1).
  - A clear does not remove a hazard in the same cycle; the instruction issues the next cycle at the earliest.
- stall_count increments on each cycle with in_valid & hazard and saturates at all-ones.
- Reset (asynchronous assert, synchronous release):
  - out_valid, register_write, illegal, all address outputs, immediate and stall_count go to 0;
  - the scoreboard is cleared.
- Reset mid-stall discards the held output and all pending bits.
- wb_valid for a register that is not pending has no effect.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: a source or rd matching wb_addr while wb_valid=1 is treated as not pending in the same cycle, so a hazard clears the cycle writeback arrives. Same-cycle set-wins still applies.
- Undefined: no bypass, as in Behaviour; issue waits one cycle after writeback.

Test Plan:
- Reset low, then released, with in_valid=0 -> all outputs 0, in_ready=1, stall_count=0.
- ALU_RI rd=3 r1=1 imm=all-ones (-1), out_ready=1 -> next cycle out_valid=1, register_write=1, addr_rd=3, immediate=32'hFFFFFFFF.
- ALU_RR rd=3 r1=1 r2=2, then ALU_RR rd=4 r1=3 r2=0 -> second instruction stalls, in_ready=0, stall_count increments each cycle.
  - wb_valid with wb_addr=3 -> second instruction accepted one cycle later (same cycle with DECODE_WB_BYPASS_EN); stall_count equals the number of stalled cycles.
- Opcode 7'h7F -> illegal=1, register_write=0, no stall for a following instruction.
- out_ready=0 for 3 cycles with valid output -> outputs stable, in_ready=0; out_ready=1 -> drains, next instruction accepted.
- ALU_RI rd=0 -> register_write=0, no pending bit; a following read of r0 does not stall.
